// File: rtl/uart_word_sched.sv
// uart_word_sched: round-robin scheduler that takes whole words from N_CH
// requesters and serialises each one as a header beat followed by
// WORD_SIZE/WORD_PART data beats, MSB first, toward a UART transmitter.
//
// Handshakes (both sides): a transfer happens on a rising clock edge where
// valid and ready are both high. Once byte_valid is raised, byte_data and
// byte_valid hold until byte_ready is seen. req_ready is a combinational
// accept strobe that is only ever raised toward a channel whose req_valid is
// high in that same cycle, so req_ready alone marks the accepted word.
//
// WORD_PART must be at least 8 so that the header {4'hA, grant_id} fits.
module uart_word_sched #(
  parameter int N_CH      = 4,
  parameter int WORD_SIZE = 32,
  parameter int WORD_PART = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      en,
  input  logic [N_CH*WORD_SIZE-1:0] req_data,
  input  logic [N_CH-1:0]           req_valid,
  output logic [N_CH-1:0]           req_ready,
  output logic [WORD_PART-1:0]      byte_data,
  output logic                      byte_valid,
  input  logic                      byte_ready,
  output logic                      busy,
  output logic [3:0]                grant_id,
  output logic [15:0]               frame_cnt,
  output logic [1:0]                state_dbg
);

  localparam int BEATS = WORD_SIZE / WORD_PART;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t               state;
  logic [3:0]           rr_ptr;
  logic [BW-1:0]        beat_cnt;
  logic [WORD_SIZE-1:0] shreg;

  logic                 win_found;
  logic [3:0]           win_idx;
  logic [WORD_SIZE-1:0] win_word;
  logic [4:0]           cand;
  logic                 accept;
  logic [WORD_PART-1:0] hdr_byte;

  // Round-robin search: first valid channel at or after rr_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_word  = '0;
    cand      = '0;
    for (int k = 0; k < N_CH; k++) begin
      cand = 5'(rr_ptr) + 5'(k);
      if (cand >= 5'(N_CH)) cand = cand - 5'(N_CH);
      for (int i = 0; i < N_CH; i++) begin
        if (!win_found && req_valid[i] && (cand == 5'(i))) begin
          win_found = 1'b1;
          win_idx   = 4'(i);
          win_word  = req_data[i*WORD_SIZE +: WORD_SIZE];
        end
      end
    end
  end

  assign accept = (state == IDLE) && en && win_found;

  // Accept strobe: one-hot on the winner, only in an IDLE cycle that grants.
  always_comb begin
    req_ready = '0;
    if (accept) begin
      for (int i = 0; i < N_CH; i++) begin
        req_ready[i] = (win_idx == 4'(i));
      end
    end
  end

  // Header beat carries a fixed tag nibble and the granted channel index.
  always_comb begin
    hdr_byte      = '0;
    hdr_byte[7:0] = {4'hA, grant_id};
  end

  // Byte-side outputs decoded purely from registered state.
  always_comb begin
    byte_valid = (state != IDLE);
    busy       = (state != IDLE);
    state_dbg  = state;
    case (state)
      HDR:     byte_data = hdr_byte;
      DATA:    byte_data = shreg[WORD_SIZE-1 -: WORD_PART];
      default: byte_data = '0;
    endcase
  end

  // Frame sequencer: grant, header, data beats, then back to IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      frame_cnt <= '0;
      beat_cnt  <= '0;
      shreg     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg    <= win_word;
            grant_id <= win_idx;
            beat_cnt <= '0;
            state    <= HDR;
          end
        end
        HDR: begin
          if (byte_ready) state <= DATA;
        end
        DATA: begin
          if (byte_ready) begin
            shreg <= shreg << WORD_PART;
            if (beat_cnt == BW'(BEATS - 1)) begin
              beat_cnt  <= '0;
              state     <= IDLE;
              rr_ptr    <= (grant_id == 4'(N_CH - 1)) ? 4'd0 : grant_id + 4'd1;
              frame_cnt <= frame_cnt + 16'd1;
            end else begin
              beat_cnt <= beat_cnt + BW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_sched.sv
// Bench for uart_word_sched: directed steps in one initial block, a
// behavioural round-robin model that pushes expected bytes into exp_q on
// every accept, and a monitor that pops and compares each accepted byte.
module tb_uart_word_sched;

  localparam int N_CH  = 4;
  localparam int WS    = 32;
  localparam int WP    = 8;
  localparam int BEATS = WS / WP;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 en = 1'b0;
  logic [N_CH*WS-1:0]   req_data;
  logic [N_CH-1:0]      req_valid = '0;
  logic [N_CH-1:0]      req_ready;
  logic [WP-1:0]        byte_data;
  logic                 byte_valid;
  logic                 byte_ready = 1'b0;
  logic                 busy;
  logic [3:0]           grant_id;
  logic [15:0]          frame_cnt;
  logic [1:0]           state_dbg;

  logic [WS-1:0]        words [N_CH];

  // scoreboard and model state
  logic [WP-1:0]        exp_q[$];
  logic [WP-1:0]        byte_log[$];
  int                   grant_log[$];
  int                   grant_cyc[$];
  int                   total = 0;
  int                   bad = 0;
  int                   cyc = 0;
  bit                   m_busy = 1'b0;
  int                   m_rr = 0;
  int                   m_grant = 0;
  logic [15:0]          m_frames = '0;

  for (genvar g = 0; g < N_CH; g++) begin : g_data
    assign req_data[g*WS +: WS] = words[g];
  end

  uart_word_sched #(.N_CH(N_CH), .WORD_SIZE(WS), .WORD_PART(WP)) dut (
    .clock(clock), .reset(reset), .en(en),
    .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .busy(busy), .grant_id(grant_id), .frame_cnt(frame_cnt),
    .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog: observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  // model + monitor: sampled on the falling edge, inputs already settled
  always @(negedge clock) begin
    logic [N_CH-1:0] exp_rdy;
    int              win;
    int              idx;
    logic [WS-1:0]   w;
    if (reset) begin
      m_busy   = 1'b0;
      m_rr     = 0;
      m_grant  = 0;
      m_frames = '0;
      exp_q.delete();
      total++;
      if ({req_ready, byte_valid, byte_data, busy, grant_id, frame_cnt} !==
          {{N_CH{1'b0}}, 1'b0, {WP{1'b0}}, 1'b0, 4'd0, 16'd0}) begin
        bad++;
        $error("FAIL reset_outputs: observed=%0h expected=0",
               {req_ready, byte_valid, byte_data, busy, grant_id, frame_cnt});
      end
    end else begin
      exp_rdy = '0;
      win     = -1;
      if (!m_busy && en) begin
        for (int k = 0; k < N_CH; k++) begin
          idx = (m_rr + k) % N_CH;
          if (win < 0 && req_valid[idx]) win = idx;
        end
      end
      if (win >= 0) exp_rdy[win] = 1'b1;
      total++;
      if (req_ready !== exp_rdy) begin
        bad++;
        $error("FAIL req_ready: observed=%0h expected=%0h", req_ready, exp_rdy);
      end
      total++;
      if ({busy, byte_valid} !== {m_busy, m_busy}) begin
        bad++;
        $error("FAIL busy_valid: observed=%0h expected=%0h", {busy, byte_valid}, {m_busy, m_busy});
      end
      total++;
      if (grant_id !== 4'(m_grant)) begin
        bad++;
        $error("FAIL grant_id: observed=%0h expected=%0h", grant_id, 4'(m_grant));
      end
      total++;
      if (frame_cnt !== m_frames) begin
        bad++;
        $error("FAIL frame_cnt: observed=%0h expected=%0h", frame_cnt, m_frames);
      end
      if (m_busy) begin
        total++;
        if (byte_data !== exp_q[0]) begin
          bad++;
          $error("FAIL byte_data: observed=%0h expected=%0h", byte_data, exp_q[0]);
        end
        if (byte_ready) begin
          byte_log.push_back(byte_data);
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin
            m_busy   = 1'b0;
            m_rr     = (m_grant + 1) % N_CH;
            m_frames = m_frames + 16'd1;
          end
        end
      end else if (win >= 0) begin
        m_busy  = 1'b1;
        m_grant = win;
        grant_log.push_back(win);
        grant_cyc.push_back(cyc);
        w = words[win];
        exp_q.push_back({4'hA, 4'(win)});
        for (int j = 0; j < BEATS; j++) exp_q.push_back(w[WS-1-j*WP -: WP]);
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((m_busy || exp_q.size() != 0) && n < budget) begin
      step(1);
      n++;
    end
    total++;
    if ((m_busy || exp_q.size() != 0) !== 1'b0) begin
      bad++;
      $error("FAIL wait_idle_timeout: observed=1 expected=0");
    end
  endtask

  function automatic logic [WP-1:0] blog(input int j);
    return (byte_log.size() > j) ? byte_log[j] : 'x;
  endfunction

  function automatic int glog(input int j);
    return (grant_log.size() > j) ? grant_log[j] : -1;
  endfunction

  // directed sequence
  initial begin
    logic [WP-1:0] exp_b[5];
    int            exp_g[5];
    bit            pat[7];
    int            n;
    int            d;
    for (int i = 0; i < N_CH; i++) words[i] = '0;
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step(1);
    total++;
    if (frame_cnt !== 16'd0) begin
      bad++;
      $error("FAIL post_reset_frame_cnt: observed=%0h expected=0", frame_cnt);
    end

    // single word on channel 2
    words[2] = 32'hDEADBEEF;
    en = 1'b1;
    byte_ready = 1'b1;
    byte_log.delete();
    grant_log.delete();
    req_valid = 4'b0100;
    step(1);
    req_valid = '0;
    wait_idle(50);
    step(1);
    exp_b = '{8'hA2, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    total++;
    if (byte_log.size() !== 5) begin
      bad++;
      $error("FAIL single_len: observed=%0d expected=5", byte_log.size());
    end
    for (int j = 0; j < 5; j++) begin
      total++;
      if (blog(j) !== exp_b[j]) begin
        bad++;
        $error("FAIL single_byte: observed=%0h expected=%0h", blog(j), exp_b[j]);
      end
    end
    total++;
    if (frame_cnt !== 16'd1) begin
      bad++;
      $error("FAIL single_frames: observed=%0h expected=1", frame_cnt);
    end
    total++;
    if (grant_log.size() !== 1) begin
      bad++;
      $error("FAIL single_grants: observed=%0d expected=1", grant_log.size());
    end

    // round-robin with all channels continuously valid
    pulse_reset();
    for (int i = 0; i < N_CH; i++) words[i] = $urandom_range(32'hFFFF_FFFF, 0);
    grant_log.delete();
    grant_cyc.delete();
    req_valid = 4'b1111;
    n = 0;
    while (grant_log.size() < 5 && n < 100) begin
      step(1);
      n++;
    end
    req_valid = '0;
    wait_idle(50);
    exp_g = '{0, 1, 2, 3, 0};
    for (int j = 0; j < 5; j++) begin
      total++;
      if (glog(j) !== exp_g[j]) begin
        bad++;
        $error("FAIL rr_order: observed=%0d expected=%0d", glog(j), exp_g[j]);
      end
    end
    for (int j = 1; j < 5; j++) begin
      d = (grant_cyc.size() > j) ? grant_cyc[j] - grant_cyc[j-1] : -1;
      total++;
      if (d !== 6) begin
        bad++;
        $error("FAIL rr_period: observed=%0d expected=6", d);
      end
    end

    // backpressure in DATA, rr now points at channel 1
    words[1] = 32'h11223344;
    byte_ready = 1'b0;
    byte_log.delete();
    req_valid = 4'b0010;
    step(1);
    req_valid = '0;
    pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      byte_ready = pat[i];
      if (!pat[i]) begin
        @(negedge clock);
        total++;
        if ({byte_valid, byte_data} !== {1'b1, 8'h22}) begin
          bad++;
          $error("FAIL stall_hold: observed=%0h expected=%0h", {byte_valid, byte_data}, {1'b1, 8'h22});
        end
      end
      step(1);
    end
    byte_ready = 1'b1;
    wait_idle(50);
    exp_b = '{8'hA1, 8'h11, 8'h22, 8'h33, 8'h44};
    for (int j = 0; j < 5; j++) begin
      total++;
      if (blog(j) !== exp_b[j]) begin
        bad++;
        $error("FAIL bp_byte: observed=%0h expected=%0h", blog(j), exp_b[j]);
      end
    end

    // en low blocks grants; en dropped mid-frame lets the frame finish
    grant_log.delete();
    en = 1'b0;
    req_valid = 4'b1111;
    step(5);
    total++;
    if (grant_log.size() !== 0) begin
      bad++;
      $error("FAIL en_low_grants: observed=%0d expected=0", grant_log.size());
    end
    en = 1'b1;
    step(1);
    step(3);
    en = 1'b0;
    wait_idle(50);
    step(4);
    total++;
    if (grant_log.size() !== 1) begin
      bad++;
      $error("FAIL en_drop_grants: observed=%0d expected=1", grant_log.size());
    end
    total++;
    if (glog(0) !== 2) begin
      bad++;
      $error("FAIL en_drop_grant_ch: observed=%0d expected=2", glog(0));
    end
    req_valid = '0;
    en = 1'b1;

    // reset after the second data beat of a channel 3 frame
    req_valid = 4'b1000;
    step(1);
    req_valid = '0;
    step(3);
    reset = 1'b1;
    @(negedge clock);
    total++;
    if ({byte_valid, byte_data, busy, state_dbg} !== {1'b0, 8'h00, 1'b0, 2'd0}) begin
      bad++;
      $error("FAIL midframe_reset: observed=%0h expected=0", {byte_valid, byte_data, busy, state_dbg});
    end
    step(1);
    reset = 1'b0;
    byte_log.delete();
    words[0] = 32'hCAFE0001;
    req_valid = 4'b1001;
    step(1);
    req_valid = '0;
    wait_idle(50);
    total++;
    if (blog(0) !== 8'hA0) begin
      bad++;
      $error("FAIL after_reset_hdr: observed=%0h expected=a0", blog(0));
    end
    total++;
    if (byte_log.size() !== 5) begin
      bad++;
      $error("FAIL after_reset_len: observed=%0d expected=5", byte_log.size());
    end

    // frame counter wrap from a preset of 0xFFFF
    step(1);
    force dut.frame_cnt = 16'hFFFF;
    m_frames = 16'hFFFF;
    step(1);
    release dut.frame_cnt;
    req_valid = 4'b0100;
    step(1);
    req_valid = '0;
    wait_idle(50);
    step(1);
    total++;
    if (frame_cnt !== 16'h0000) begin
      bad++;
      $error("FAIL frame_wrap: observed=%0h expected=0", frame_cnt);
    end

    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $error("FAIL scoreboard_empty: observed=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_word_sched.md
UART_WORD_SCHED -- requirements
Module: uart_word_sched

Interface
REQ-001 Parameter N_CH, default 4, number of word requesters; legal range 2..15.
REQ-002 Parameter WORD_SIZE, default 32, width of each requester word in bits.
REQ-003 Parameter WORD_PART, default 8, width of each byte-side beat; WORD_SIZE SHALL be an integer multiple of WORD_PART.
REQ-004 Port clock  input  1  rising-edge clock for all state.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port en  input  1  high permits new grants; low blocks new grants only.
REQ-007 Port req_data  input  N_CH*WORD_SIZE  requester words; channel i occupies bits [i*WORD_SIZE +: WORD_SIZE].
REQ-008 Port req_valid  input  N_CH  per-channel word valid.
REQ-009 Port req_ready  output  N_CH  per-channel accept strobe, at most one bit high.
REQ-010 Port byte_data  output  WORD_PART  byte toward the UART transmitter.
REQ-011 Port byte_valid  output  1  byte_data valid.
REQ-012 Port byte_ready  input  1  transmitter accepts byte_data.
REQ-013 Port busy  output  1  high while a frame is being emitted.
REQ-014 Port grant_id  output  4  channel index of the current or most recent frame.
REQ-015 Port frame_cnt  output  16  count of completed frames, wraps 0xFFFF->0x0000.

Function
REQ-016 The block SHALL implement FSM states IDLE, HDR, DATA.
REQ-017 IDLE: with en=1 and any req_valid set, winner = first set req_valid index at or after rr_ptr, searching upward with wrap from N_CH-1 to 0.
REQ-018 IDLE: req_ready SHALL be combinationally one-hot on the winner in that cycle and zero otherwise; all req_ready bits zero in HDR and DATA.
REQ-019 On the IDLE accept cycle the block SHALL capture the winner's word into a shift register, set grant_id=winner, and enter HDR next cycle.
REQ-020 HDR: byte_valid=1, byte_data = {4'hA, grant_id} (upper WORD_PART-8 bits zero if WORD_PART>8); advance to DATA on byte_valid & byte_ready.
REQ-021 DATA: byte_valid=1, byte_data = the most-significant WORD_PART bits of the shift register; on each byte_ready the register shifts left by WORD_PART and a beat counter increments.
REQ-022 After beat WORD_SIZE/WORD_PART is accepted: return to IDLE, rr_ptr = (grant_id+1) mod N_CH, frame_cnt += 1.
REQ-023 byte_data and byte_valid SHALL hold stable while byte_valid=1 and byte_ready=0.
REQ-024 byte_valid SHALL be 0 in IDLE; byte_ready in IDLE is ignored.
REQ-025 busy SHALL be 1 in HDR and DATA, 0 in IDLE.
REQ-026 Latency: word accepted at cycle t gives header byte_valid at t+1; with byte_ready held high, data beats occupy t+2..t+1+WORD_SIZE/WORD_PART and IDLE is reentered at the following cycle.
REQ-027 Back-to-back frames: IDLE lasts at least one cycle between frames; a new grant is allowed on the first IDLE cycle.
REQ-028 en deasserted mid-frame SHALL NOT abort the frame; it blocks only the next grant.
REQ-029 A req_valid dropping in a cycle where it would win SHALL NOT be accepted; arbitration uses current-cycle req_valid only.
REQ-030 A channel whose req_valid stays high SHALL be granted within N_CH frames (round-robin fairness).

Reset
REQ-031 While reset is high: state=IDLE, rr_ptr=0, grant_id=0, frame_cnt=0, beat counter and shift register zero, req_ready=0, byte_valid=0, byte_data=0, busy=0.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame; no further beats of it are emitted after release.

Verification
REQ-033 Single word: ch2 presents 0xDEADBEEF, byte_ready=1 -> bytes 0xA2,0xDE,0xAD,0xBE,0xEF on consecutive cycles; frame_cnt=1; req_ready[2] pulsed once.
REQ-034 Round-robin: all four channels valid continuously -> grants in order 0,1,2,3,0; one IDLE cycle between frames, 6-cycle period.
REQ-035 Backpressure: byte_ready toggles 1,0,0,1 mid-DATA -> byte_data/byte_valid constant during the stalls; byte order unchanged.
REQ-036 en=0 with req_valid=4'b1111 -> no req_ready, byte_valid=0; en dropped during DATA -> frame completes, no next grant.
REQ-037 Reset asserted after second data beat -> outputs zero next cycle; after release, ch0 valid produces header 0xA0 (rr_ptr=0).
REQ-038 frame_cnt preset by 65535 frames -> next completion wraps to 0x0000.
